// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the split-access load/store unit.
package lsu_pkg;

  // Control FSM states; exported on dbg_state for checkers.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;

  // RISC-V funct3 codes for loads
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // RISC-V funct3 codes for stores
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;
  localparam logic [2:0] SD = 3'b011;

  // Access size in bytes from funct3[1:0].
  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Legal funct3 codes; the 64-bit-only forms need wide=1.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3, input logic wide);
    if (we)
      return (f3 == SB) || (f3 == SH) || (f3 == SW) || (wide && (f3 == SD));
    else
      return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU) ||
             (wide && ((f3 == LD) || (f3 == LWU)));
  endfunction

endpackage

// File: rtl/lsu_split_access_if.sv
// Core-side and bus-side channels of the load/store unit.
//
// Handshake rules for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high. The source holds valid, and every
// qualified field, stable until that edge. The sink may drive ready at any
// time, and ready may depend on valid. resp_valid and mem_rvalid are one-cycle
// pulses with no back-pressure.
interface lsu_req_if import lsu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int AW   = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [AW-1:0]   req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if import lsu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int AW   = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_req_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_req_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: byte enables and store data for either beat,
// plus extraction and extension of load data from the two beat words.
module lsu_lane_align import lsu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2:0]                  funct3,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  logic                        second,
  input  logic [XLEN-1:0]             wdata,
  input  logic [XLEN-1:0]             lo,
  input  logic [XLEN-1:0]             hi,
  output logic [XLEN/8-1:0]           be,
  output logic [XLEN-1:0]             beat_wdata,
  output logic [XLEN-1:0]             load_data
);
  localparam int NB = XLEN / 8;

  logic [3:0]        bytes;
  logic [2*NB-1:0]   be_full;
  logic [2*XLEN-1:0] w_full;
  logic [XLEN-1:0]   r_low;
  logic [31:0]       nbits;
  logic              sign;

  assign bytes = size_bytes(funct3[1:0]);

  // Mask and data laid out over two bus words; the upper half is the second beat.
  assign be_full    = ~({2*NB{1'b1}} << bytes) << off;
  assign w_full     = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
  assign be         = second ? be_full[2*NB-1:NB] : be_full[NB-1:0];
  assign beat_wdata = second ? w_full[2*XLEN-1:XLEN] : w_full[XLEN-1:0];

  // Bring the addressed byte down to bit 0 of the concatenated beats.
  assign r_low = XLEN'({hi, lo} >> {off, 3'b000});

  // Keep the accessed bytes, then sign- or zero-extend from the top accessed bit.
  always_comb begin
    load_data = '0;
    sign      = 1'b0;
    nbits     = {25'd0, bytes, 3'b000};
    if (nbits > XLEN) nbits = XLEN;
    for (int i = 0; i < XLEN; i++) begin
      if (i == nbits - 32'd1) sign = r_low[i];
    end
    for (int i = 0; i < XLEN; i++) begin
      load_data[i] = (i < nbits) ? r_low[i] : (sign & ~funct3[2]);
    end
  end

endmodule

// File: rtl/lsu_split_access.sv
// Load/store unit between execute and the data bus. Turns one core request
// into one or two aligned bus beats, with a per-state stall timeout.
module lsu_split_access import lsu_pkg::*; #(
  parameter int XLEN             = 32,
  parameter int AW               = 32,
  parameter int ALLOW_MISALIGNED = 1,
  parameter int TIMEOUT          = 255
) (
  input  logic       CLK,
  input  logic       resetn,
  lsu_req_if.slave   core,
  lsu_mem_if.master  mem,
  output state_t     dbg_state
);
  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] lo_q;
  logic            split_q;
  logic [CW-1:0]   cnt;

  logic [OFS-1:0]  req_off;
  logic [3:0]      req_bytes;
  logic            req_split;
  logic            req_legal;
  logic [AW-1:0]   base_addr;
  logic            in_req;
  logic            timeout;
  logic [NB-1:0]   lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] lo_in;

  // Decode of the incoming request, used only at capture time.
  assign req_off   = core.req_addr[OFS-1:0];
  assign req_bytes = size_bytes(core.req_funct3[1:0]);
  assign req_split = (int'(req_off) + int'(req_bytes)) > NB;
  assign req_legal = funct3_legal(core.req_we, core.req_funct3, XLEN == 64);

  assign base_addr = {addr_q[AW-1:OFS], {OFS{1'b0}}};
  assign in_req    = (state == REQ0) || (state == REQ1);
  assign timeout   = (cnt == CNT_LAST);

  // In WAIT0 the low word is still on the bus; later it comes from lo_q.
  assign lo_in = (state == WAIT0) ? mem.mem_rdata : lo_q;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .funct3     (f3_q),
    .off        (addr_q[OFS-1:0]),
    .second     (state == REQ1),
    .wdata      (wdata_q),
    .lo         (lo_in),
    .hi         (mem.mem_rdata),
    .be         (lane_be),
    .beat_wdata (lane_wdata),
    .load_data  (load_data)
  );

  // Bus outputs are quiet outside the request states; REQ1 address wraps naturally.
  assign core.req_ready    = (state == IDLE);
  assign mem.mem_req_valid = in_req;
  assign mem.mem_we        = in_req & we_q;
  assign mem.mem_addr      = !in_req ? '0 : ((state == REQ1) ? base_addr + AW'(NB) : base_addr);
  assign mem.mem_be        = in_req ? lane_be : '0;
  assign mem.mem_wdata     = in_req ? lane_wdata : '0;
  assign dbg_state         = state;

  // Request capture, beat sequencing, stall timeout and the registered response pulse.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state           <= IDLE;
      we_q            <= 1'b0;
      f3_q            <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      lo_q            <= '0;
      split_q         <= 1'b0;
      cnt             <= '0;
      core.resp_valid <= 1'b0;
      core.resp_err   <= 1'b0;
      core.resp_rdata <= '0;
    end else begin
      core.resp_valid <= 1'b0;
      core.resp_err   <= 1'b0;
      core.resp_rdata <= '0;
      cnt             <= '0;
      case (state)
        IDLE: begin
          if (core.req_valid) begin
            we_q    <= core.req_we;
            f3_q    <= core.req_funct3;
            addr_q  <= core.req_addr;
            wdata_q <= core.req_wdata;
            split_q <= req_split;
            if (!req_legal || (req_split && ALLOW_MISALIGNED == 0)) begin
              state           <= RESP;
              core.resp_valid <= 1'b1;
              core.resp_err   <= 1'b1;
            end else begin
              state <= REQ0;
            end
          end
        end
        REQ0: begin
          if (mem.mem_req_ready) begin
            if (!we_q) begin
              state <= WAIT0;
            end else if (split_q) begin
              state <= REQ1;
            end else begin
              state           <= RESP;
              core.resp_valid <= 1'b1;
            end
          end else if (timeout) begin
            state           <= RESP;
            core.resp_valid <= 1'b1;
            core.resp_err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT0: begin
          if (mem.mem_rvalid) begin
            lo_q <= mem.mem_rdata;
            if (split_q) begin
              state <= REQ1;
            end else begin
              state           <= RESP;
              core.resp_valid <= 1'b1;
              core.resp_rdata <= load_data;
            end
          end else if (timeout) begin
            state           <= RESP;
            core.resp_valid <= 1'b1;
            core.resp_err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        REQ1: begin
          if (mem.mem_req_ready) begin
            if (we_q) begin
              state           <= RESP;
              core.resp_valid <= 1'b1;
            end else begin
              state <= WAIT1;
            end
          end else if (timeout) begin
            state           <= RESP;
            core.resp_valid <= 1'b1;
            core.resp_err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT1: begin
          if (mem.mem_rvalid) begin
            state           <= RESP;
            core.resp_valid <= 1'b1;
            core.resp_rdata <= load_data;
          end else if (timeout) begin
            state           <= RESP;
            core.resp_valid <= 1'b1;
            core.resp_err   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_split_access.sv
// Directed bench for lsu_split_access. dut_a splits misaligned accesses and
// has a short timeout; dut_b rejects misaligned accesses.
module tb_lsu_split_access;
  import lsu_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 32;

  logic   CLK = 1'b0;
  logic   resetn = 1'b0;
  state_t st_a;
  state_t st_b;
  int     n_vec = 0;
  int     n_err = 0;

  logic [XLEN:0] exp_q[$];
  logic [XLEN:0] exp_resp;

  lsu_req_if #(.XLEN(XLEN), .AW(AW)) ra();
  lsu_mem_if #(.XLEN(XLEN), .AW(AW)) ma();
  lsu_req_if #(.XLEN(XLEN), .AW(AW)) rb();
  lsu_mem_if #(.XLEN(XLEN), .AW(AW)) mb();

  lsu_split_access #(.XLEN(XLEN), .AW(AW), .ALLOW_MISALIGNED(1), .TIMEOUT(4)) dut_a (
    .CLK(CLK), .resetn(resetn), .core(ra), .mem(ma), .dbg_state(st_a)
  );

  lsu_split_access #(.XLEN(XLEN), .AW(AW), .ALLOW_MISALIGNED(0), .TIMEOUT(255)) dut_b (
    .CLK(CLK), .resetn(resetn), .core(rb), .mem(mb), .dbg_state(st_b)
  );

  // clock
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every dut_a response is matched against the expected queue
  always @(negedge CLK) begin
    if (ra.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("a_spurious_resp", ra.resp_valid, 1'b0);
      end else begin
        exp_resp = exp_q.pop_front();
        chk("a_resp_err", ra.resp_err, exp_resp[XLEN]);
        chk("a_resp_rdata", ra.resp_rdata, exp_resp[XLEN-1:0]);
      end
    end
  end

  // driver: present a request at a negedge, return at the next negedge
  task automatic send_a(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                        input logic [XLEN-1:0] wdata);
    chk("a_req_ready", ra.req_ready, 1'b1);
    ra.req_valid  = 1'b1;
    ra.req_we     = we;
    ra.req_funct3 = f3;
    ra.req_addr   = addr;
    ra.req_wdata  = wdata;
    @(negedge CLK);
    ra.req_valid = 1'b0;
  endtask

  task automatic send_b(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                        input logic [XLEN-1:0] wdata);
    chk("b_req_ready", rb.req_ready, 1'b1);
    rb.req_valid  = 1'b1;
    rb.req_we     = we;
    rb.req_funct3 = f3;
    rb.req_addr   = addr;
    rb.req_wdata  = wdata;
    @(negedge CLK);
    rb.req_valid = 1'b0;
  endtask

  task automatic beat_a(input logic [AW-1:0] addr, input logic [3:0] be, input logic we,
                        input logic [XLEN-1:0] wdata);
    chk("a_mem_req_valid", ma.mem_req_valid, 1'b1);
    chk("a_mem_addr", ma.mem_addr, addr);
    chk("a_mem_be", ma.mem_be, be);
    chk("a_mem_we", ma.mem_we, we);
    if (we) chk("a_mem_wdata", ma.mem_wdata, wdata);
  endtask

  // bus read-data pulse given in a WAIT cycle
  task automatic rdata_a(input logic [XLEN-1:0] d);
    chk("a_wait_no_req", ma.mem_req_valid, 1'b0);
    chk("a_wait_be_zero", ma.mem_be, 4'h0);
    ma.mem_rvalid = 1'b1;
    ma.mem_rdata  = d;
    @(negedge CLK);
    ma.mem_rvalid = 1'b0;
  endtask

  task automatic load_a(input logic [2:0] f3, input logic [AW-1:0] addr, input logic [AW-1:0] baddr,
                        input logic [3:0] be, input logic [XLEN-1:0] rd, input logic [XLEN-1:0] res);
    exp_q.push_back({1'b0, res});
    send_a(1'b0, f3, addr, '0);
    beat_a(baddr, be, 1'b0, '0);
    @(negedge CLK);
    rdata_a(rd);
    chk("a_load_latency", ra.resp_valid, 1'b1);
    @(negedge CLK);
  endtask

  task automatic store_a(input logic [2:0] f3, input logic [AW-1:0] addr, input logic [XLEN-1:0] wd,
                         input logic [AW-1:0] baddr, input logic [3:0] be, input logic [XLEN-1:0] bwd);
    exp_q.push_back({1'b0, 32'h0});
    send_a(1'b1, f3, addr, wd);
    beat_a(baddr, be, 1'b1, bwd);
    @(negedge CLK);
    chk("a_store_latency", ra.resp_valid, 1'b1);
    @(negedge CLK);
  endtask

  initial begin
    ra.req_valid = 1'b0; ra.req_we = 1'b0; ra.req_funct3 = '0; ra.req_addr = '0; ra.req_wdata = '0;
    rb.req_valid = 1'b0; rb.req_we = 1'b0; rb.req_funct3 = '0; rb.req_addr = '0; rb.req_wdata = '0;
    ma.mem_req_ready = 1'b1; ma.mem_rvalid = 1'b0; ma.mem_rdata = '0;
    mb.mem_req_ready = 1'b1; mb.mem_rvalid = 1'b0; mb.mem_rdata = '0;

    // reset
    resetn = 1'b0;
    repeat (3) @(negedge CLK);
    chk("a_rst_state", st_a, IDLE);
    chk("b_rst_state", st_b, IDLE);
    chk("a_rst_resp_valid", ra.resp_valid, 1'b0);
    chk("a_rst_resp_err", ra.resp_err, 1'b0);
    chk("a_rst_resp_rdata", ra.resp_rdata, 32'h0);
    chk("a_rst_mem_req_valid", ma.mem_req_valid, 1'b0);
    chk("a_rst_mem_be", ma.mem_be, 4'h0);
    chk("b_rst_resp_valid", rb.resp_valid, 1'b0);
    chk("b_rst_mem_req_valid", mb.mem_req_valid, 1'b0);
    resetn = 1'b1;
    @(negedge CLK);

    // aligned stores
    store_a(SW, 32'h100, 32'hDEADBEEF, 32'h100, 4'hF, 32'hDEADBEEF);
    chk("a_idle_after_store", ra.req_ready, 1'b1);
    store_a(SB, 32'h101, 32'h123456A5, 32'h100, 4'h2, 32'h3456A500);

    // aligned loads, sign and zero extension
    load_a(LB,  32'h103, 32'h100, 4'h8, 32'h80FFFFFF, 32'hFFFFFF80);
    load_a(LBU, 32'h103, 32'h100, 4'h8, 32'h80FFFFFF, 32'h00000080);
    load_a(LH,  32'h101, 32'h100, 4'h6, 32'h00ABCD00, 32'hFFFFABCD);
    load_a(LHU, 32'h102, 32'h100, 4'hC, 32'h7FFF0000, 32'h00007FFF);

    // misaligned word load split over two beats
    exp_q.push_back({1'b0, 32'hCCCCBBBB});
    send_a(1'b0, LW, 32'h102, '0);
    beat_a(32'h100, 4'hC, 1'b0, '0);
    @(negedge CLK);
    rdata_a(32'hBBBBAAAA);
    beat_a(32'h104, 4'h3, 1'b0, '0);
    @(negedge CLK);
    rdata_a(32'hDDDDCCCC);
    chk("a_split_load_resp", ra.resp_valid, 1'b1);
    @(negedge CLK);

    // misaligned halfword store
    exp_q.push_back({1'b0, 32'h0});
    send_a(1'b1, SH, 32'h3, 32'h00001234);
    beat_a(32'h0, 4'h8, 1'b1, 32'h34000000);
    @(negedge CLK);
    beat_a(32'h4, 4'h1, 1'b1, 32'h00000012);
    @(negedge CLK);
    chk("a_split_store_resp", ra.resp_valid, 1'b1);
    @(negedge CLK);

    // misaligned word store at offset 1
    exp_q.push_back({1'b0, 32'h0});
    send_a(1'b1, SW, 32'h1, 32'hDEADBEEF);
    beat_a(32'h0, 4'hE, 1'b1, 32'hADBEEF00);
    @(negedge CLK);
    beat_a(32'h4, 4'h1, 1'b1, 32'h000000DE);
    @(negedge CLK);
    @(negedge CLK);

    // second-beat address wraps past the top of the address space
    exp_q.push_back({1'b0, 32'h33445566});
    send_a(1'b0, LW, 32'hFFFFFFFE, '0);
    beat_a(32'hFFFFFFFC, 4'hC, 1'b0, '0);
    @(negedge CLK);
    rdata_a(32'h55667788);
    beat_a(32'h00000000, 4'h3, 1'b0, '0);
    @(negedge CLK);
    rdata_a(32'h11223344);
    @(negedge CLK);

    // illegal funct3: LD on a 32-bit unit, and store code 100
    exp_q.push_back({1'b1, 32'h0});
    send_a(1'b0, LD, 32'h200, '0);
    chk("a_illegal_ld_no_bus", ma.mem_req_valid, 1'b0);
    chk("a_illegal_ld_resp", ra.resp_valid, 1'b1);
    @(negedge CLK);
    exp_q.push_back({1'b1, 32'h0});
    send_a(1'b1, 3'b100, 32'h200, 32'hFFFFFFFF);
    chk("a_illegal_st_no_bus", ma.mem_req_valid, 1'b0);
    @(negedge CLK);

    // misaligned rejected when splitting is disabled
    send_b(1'b1, SH, 32'h3, 32'h00001234);
    chk("b_mis_no_bus", mb.mem_req_valid, 1'b0);
    chk("b_mis_resp_valid", rb.resp_valid, 1'b1);
    chk("b_mis_resp_err", rb.resp_err, 1'b1);
    chk("b_mis_resp_rdata", rb.resp_rdata, 32'h0);
    @(negedge CLK);
    chk("b_mis_one_pulse", rb.resp_valid, 1'b0);
    chk("b_mis_no_bus_after", mb.mem_req_valid, 1'b0);

    // aligned load still works with splitting disabled
    send_b(1'b0, LW, 32'h8, '0);
    chk("b_lw_addr", mb.mem_addr, 32'h8);
    chk("b_lw_be", mb.mem_be, 4'hF);
    @(negedge CLK);
    mb.mem_rvalid = 1'b1;
    mb.mem_rdata  = 32'h89ABCDEF;
    @(negedge CLK);
    mb.mem_rvalid = 1'b0;
    chk("b_lw_resp_valid", rb.resp_valid, 1'b1);
    chk("b_lw_resp_err", rb.resp_err, 1'b0);
    chk("b_lw_resp_rdata", rb.resp_rdata, 32'h89ABCDEF);
    @(negedge CLK);

    // timeout in REQ0: four request cycles, then an error response
    ma.mem_req_ready = 1'b0;
    exp_q.push_back({1'b1, 32'h0});
    send_a(1'b0, LW, 32'h10, '0);
    chk("a_to0_req_first", ma.mem_req_valid, 1'b1);
    repeat (3) @(negedge CLK);
    chk("a_to0_req_fourth", ma.mem_req_valid, 1'b1);
    chk("a_to0_not_yet", ra.resp_valid, 1'b0);
    @(negedge CLK);
    chk("a_to0_resp", ra.resp_valid, 1'b1);
    chk("a_to0_bus_released", ma.mem_req_valid, 1'b0);
    ma.mem_req_ready = 1'b1;
    ma.mem_rvalid    = 1'b1;
    ma.mem_rdata     = 32'hCAFEF00D;
    @(negedge CLK);
    ma.mem_rvalid = 1'b0;
    chk("a_to0_ready_back", ra.req_ready, 1'b1);
    chk("a_to0_late_ignored", ra.resp_valid, 1'b0);
    @(negedge CLK);

    // timeout in WAIT0: accepted beat, read data never returns
    exp_q.push_back({1'b1, 32'h0});
    send_a(1'b0, LW, 32'h20, '0);
    beat_a(32'h20, 4'hF, 1'b0, '0);
    repeat (4) @(negedge CLK);
    chk("a_to1_not_yet", ra.resp_valid, 1'b0);
    @(negedge CLK);
    chk("a_to1_resp", ra.resp_valid, 1'b1);
    @(negedge CLK);

    // reset while waiting for the second beat abandons the access
    send_a(1'b0, LW, 32'h102, '0);
    @(negedge CLK);
    rdata_a(32'h01020304);
    @(negedge CLK);
    chk("a_in_wait1", st_a, WAIT1);
    resetn = 1'b0;
    @(negedge CLK);
    resetn = 1'b1;
    chk("a_rst_mid_state", st_a, IDLE);
    chk("a_rst_mid_req_valid", ma.mem_req_valid, 1'b0);
    chk("a_rst_mid_no_resp", ra.resp_valid, 1'b0);
    load_a(LW, 32'h0, 32'h0, 4'hF, 32'h13579BDF, 32'h13579BDF);

    chk("a_all_resps_seen", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_split_access.md
Name: lsu_split_access

Overview:
- Parametrised next-generation load/store unit sitting between the execute stage and the data-memory bus.
- Accepts one load or store per valid/ready handshake and generates aligned bus transactions with byte enables, lane-shifted store data and sign/zero-extended load data.
- Transparently splits misaligned accesses into two bus beats, or flags them as errors when splitting is disabled.
- Aborts with an error if the bus stalls beyond a timeout.

Parameters:
- XLEN, 32: data/bus width in bits; legal values 32 or 64. NB = XLEN/8, OFS = log2(NB).
- AW, 32: address width.
- ALLOW_MISALIGNED, 1: 1 = split misaligned accesses into two beats; 0 = respond with error and issue no bus traffic.
- TIMEOUT, 255: max cycles spent in any single bus-wait state before abort; counter width is clog2(TIMEOUT+1).

Ports:
- CLK  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  unit idle and accepting a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width/sign code
- req_addr  in  AW  byte address
- req_wdata  in  XLEN  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid: misaligned (when disallowed), illegal funct3, or timeout
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_we  out  1  bus write
- mem_addr  out  AW  NB-aligned address
- mem_be  out  NB  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_rvalid  in  1  bus read data valid
- mem_rdata  in  XLEN  bus read data

Behaviour:
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP. Reset → IDLE.
- Reset values: resp_valid=0, resp_err=0, resp_rdata=0, mem_req_valid=0, internal buffers=0.
- req_ready=1 only in IDLE.
- Reset mid-operation abandons the transaction without a response.
- Size decode: bytes=1/2/4/8 for funct3[1:0]=00/01/10/11.
  - Legal loads: 000, 001, 010, 100, 101; plus 011 (LD) and 110 (LWU) when XLEN=64.
  - Legal stores: 000, 001, 010; plus 011 when XLEN=64.
  - Anything else is illegal.
- Request capture: in IDLE, on req_valid the unit latches we, funct3, addr, wdata. off = addr[OFS-1:0]; split = (off+bytes > NB).
  - Illegal funct3, or split with ALLOW_MISALIGNED=0 → RESP with err=1, no bus beat.
  - Otherwise → REQ0.
- REQ0: mem_req_valid=1.
  - mem_addr = addr with low OFS bits cleared.
  - mem_be = ((1<<bytes)-1) << off, truncated to NB.
  - mem_wdata = wdata << 8*off.
  - On mem_req_ready: loads → WAIT0; stores → REQ1 if split, else RESP.
- WAIT0: on mem_rvalid, capture lo=mem_rdata; → REQ1 if split, else RESP.
- REQ1: mem_addr = aligned address + NB; mem_be = ((1<<bytes)-1) >> (NB-off); mem_wdata = wdata >> 8*(NB-off).
  - On mem_req_ready: loads → WAIT1; stores → RESP.
- WAIT1: on mem_rvalid, capture hi; → RESP.
- Load assembly: {hi,lo} >> 8*off, low `bytes` bytes kept, then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) to XLEN.
- mem_* outputs are driven only in REQ states: mem_be=0 and mem_req_valid=0 elsewhere. mem_rvalid outside WAIT states is ignored.
- Address wrap: the REQ1 address wraps modulo 2^AW.
- Timeout: a cycle counter clears on every state change and increments each cycle in REQ0/WAIT0/REQ1/WAIT1. When it reaches TIMEOUT → RESP with err=1 and rdata=0; any late bus response is ignored.
- RESP: resp_valid=1 for exactly one cycle, outputs registered; → IDLE.
  - Minimum latency: aligned store 2 cycles from acceptance to resp_valid (REQ0 with ready, RESP); aligned load with same-cycle rvalid 3 cycles.
  - The next request can be accepted on the cycle after RESP.

Decomposition:
- Package lsu_pkg: state enum, funct3 constants (LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD), and a size-decode function.
- One sub-module, lsu_lane_align: combinational byte-enable generation, store-data shift and load extract/extend, parametrised by XLEN.

Test Plan:
- XLEN=32, SW addr 0x100, data 0xDEADBEEF, ready=1 → single beat mem_addr=0x100, be=1111, wdata=0xDEADBEEF; resp_valid 2 cycles after acceptance, err=0.
- LB addr 0x103, mem_rdata=0x80FFFFFF → be=1000; resp_rdata=0xFFFFFF80. LBU at the same address → 0x00000080.
- Misaligned LW addr 0x102, beats return 0xBBBBAAAA then 0xDDDDCCCC → two beats at 0x100/0x104 with be=1100/0011; resp_rdata=0xCCCCBBBB.
- Misaligned SH addr 0x3, data 0x1234 → beat0 be=1000, wdata[31:24]=0x34; beat1 addr 0x4, be=0001, wdata[7:0]=0x12. With ALLOW_MISALIGNED=0 → no mem_req_valid; resp_err=1 one cycle after acceptance.
- TIMEOUT=4, load with mem_req_ready held 0 → resp_valid with err=1 after 4 REQ0 cycles; a late mem_rvalid is ignored and req_ready returns.
- resetn low while in WAIT1 → next cycle IDLE, mem_req_valid=0, no resp_valid; a following LW at 0x0 completes normally.
